// File: rtl/vdac_pkg.sv
// Shared encodings and grey-conversion weights for the vdac colour stage.
package vdac_pkg;

  typedef enum logic [1:0] {
    VDAC_SCALE = 2'd0,
    VDAC_REPL  = 2'd1,
    VDAC_GREY  = 2'd2,
    VDAC_RSVD  = 2'd3
  } vdac_mode_e;

  // Y = (5R + 9G + 2B) >> 4; the weights sum to 2^GREY_SH so Y never exceeds full scale.
  localparam int GREY_WR = 5;
  localparam int GREY_WG = 9;
  localparam int GREY_WB = 2;
  localparam int GREY_SH = 4;

endpackage

// File: rtl/vdac_lut.sv
// Combinational code -> OUT_W map: clamped-linear scale and MSB-first bit replication.
module vdac_lut #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8,
  parameter int MAXV  = 24
) (
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] scale_v,
  output logic [OUT_W-1:0] repl_v
);

  localparam int N = 1 << IN_W;

  function automatic logic [OUT_W-1:0] scale_of(input int c);
    longint cc;
    cc = (c > MAXV) ? longint'(MAXV) : longint'(c);
    return OUT_W'((cc * ((longint'(1) << OUT_W) - longint'(1))) / longint'(MAXV));
  endfunction

  function automatic logic [OUT_W-1:0] repl_of(input int c);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int j = 0; j < OUT_W; j++) begin
      v[OUT_W-1-j] = c[IN_W-1-(j % IN_W)];
    end
    return v;
  endfunction

  logic [OUT_W-1:0] rom_s [N];
  logic [OUT_W-1:0] rom_r [N];

  for (genvar i = 0; i < N; i++) begin : g_rom
    assign rom_s[i] = scale_of(i);
    assign rom_r[i] = repl_of(i);
  end

  assign scale_v = rom_s[code];
  assign repl_v  = rom_r[code];

endmodule

// File: rtl/vdac_pipe.sv
// Three-stage video DAC colour pipe with frame-synchronous mode/fade shadowing.
module vdac_pipe
  import vdac_pkg::*;
#(
  parameter int IN_W     = 5,
  parameter int OUT_W    = 8,
  parameter int MAXV     = 24,
  parameter int FADE_W   = 4,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   r_in,
  input  logic [IN_W-1:0]   g_in,
  input  logic [IN_W-1:0]   b_in,
  input  logic              blank,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [1:0]        mode,
  input  logic [FADE_W:0]   fade_target,
  input  logic [FADE_W-1:0] fade_rate,
  output logic [OUT_W-1:0]  r_o,
  output logic [OUT_W-1:0]  g_o,
  output logic [OUT_W-1:0]  b_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              fade_busy
);

  localparam logic [FADE_W:0] FULL = {1'b1, {FADE_W{1'b0}}};
  localparam int YS_W = OUT_W + GREY_SH;

  logic [IN_W-1:0]  r1, g1, b1;
  logic             bl1, hs1, vs1, ld1, vs_prev;
  logic             vs_act1, frame_start;
  logic [OUT_W-1:0] sc_r, sc_g, sc_b, rp_r, rp_g, rp_b;
  logic [OUT_W-1:0] r2, g2, b2;
  logic             grey2, bl2, hs2, vs2;
  vdac_mode_e       mode_sh, mode_eff;
  logic [FADE_W:0]  level, tgt_sh, tgt_new, lvl_next, rate_x;
  logic [YS_W-1:0]  y_sum;
  logic [OUT_W-1:0] y, c_r, c_g, c_b;

  function automatic logic [OUT_W-1:0] bright(input logic [OUT_W-1:0] v, input logic [FADE_W:0] lvl);
    logic [OUT_W+FADE_W:0] p;
    p = {{(FADE_W+1){1'b0}}, v} * {{OUT_W{1'b0}}, lvl};
    return OUT_W'(p >> FADE_W);
  endfunction

  // Stage 1: register raw inputs; vs_prev is held active until real vsync data has been seen,
  // so a vsync already asserted across reset cannot fake a frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1      <= '0;
      g1      <= '0;
      b1      <= '0;
      bl1     <= 1'b1;
      hs1     <= SYNC_NEG;
      vs1     <= SYNC_NEG;
      ld1     <= 1'b0;
      vs_prev <= 1'b1;
    end else begin
      r1      <= r_in;
      g1      <= g_in;
      b1      <= b_in;
      bl1     <= blank;
      hs1     <= hsync;
      vs1     <= vsync;
      ld1     <= 1'b1;
      vs_prev <= ld1 ? vs_act1 : 1'b1;
    end
  end

  assign vs_act1     = vs1 ^ SYNC_NEG;
  assign frame_start = vs_act1 & ~vs_prev;

  vdac_lut #(.IN_W(IN_W), .OUT_W(OUT_W), .MAXV(MAXV)) u_lut_r (.code(r1), .scale_v(sc_r), .repl_v(rp_r));
  vdac_lut #(.IN_W(IN_W), .OUT_W(OUT_W), .MAXV(MAXV)) u_lut_g (.code(g1), .scale_v(sc_g), .repl_v(rp_g));
  vdac_lut #(.IN_W(IN_W), .OUT_W(OUT_W), .MAXV(MAXV)) u_lut_b (.code(b1), .scale_v(sc_b), .repl_v(rp_b));

  assign mode_eff = (mode_sh == VDAC_RSVD) ? VDAC_SCALE : mode_sh;

  // Stage 2: code conversion; greyscale uses the scale path and is flagged for stage 3.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2    <= '0;
      g2    <= '0;
      b2    <= '0;
      grey2 <= 1'b0;
      bl2   <= 1'b1;
      hs2   <= SYNC_NEG;
      vs2   <= SYNC_NEG;
    end else begin
      r2    <= (mode_eff == VDAC_REPL) ? rp_r : sc_r;
      g2    <= (mode_eff == VDAC_REPL) ? rp_g : sc_g;
      b2    <= (mode_eff == VDAC_REPL) ? rp_b : sc_b;
      grey2 <= (mode_eff == VDAC_GREY);
      bl2   <= bl1;
      hs2   <= hs1;
      vs2   <= vs1;
    end
  end

  assign y_sum = YS_W'(GREY_WR * int'(r2) + GREY_WG * int'(g2) + GREY_WB * int'(b2));
  assign y     = OUT_W'(y_sum >> GREY_SH);
  assign c_r   = grey2 ? y : r2;
  assign c_g   = grey2 ? y : g2;
  assign c_b   = grey2 ? y : b2;

  // Stage 3: greyscale mix, brightness scaling and blanking into the output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o     <= '0;
      g_o     <= '0;
      b_o     <= '0;
      hsync_o <= SYNC_NEG;
      vsync_o <= SYNC_NEG;
    end else begin
      r_o     <= bl2 ? '0 : bright(c_r, level);
      g_o     <= bl2 ? '0 : bright(c_g, level);
      b_o     <= bl2 ? '0 : bright(c_b, level);
      hsync_o <= hs2;
      vsync_o <= vs2;
    end
  end

  assign tgt_new = (fade_target > FULL) ? FULL : fade_target;
  assign rate_x  = {1'b0, fade_rate};

  // Next fade level: step toward the freshly clamped target, landing on it rather than overshooting.
  always_comb begin
    lvl_next = level;
    if (fade_rate == '0) begin
      lvl_next = tgt_new;
    end else if (level < tgt_new) begin
      lvl_next = ((tgt_new - level) <= rate_x) ? tgt_new : level + rate_x;
    end else if (level > tgt_new) begin
      lvl_next = ((level - tgt_new) <= rate_x) ? tgt_new : level - rate_x;
    end
  end

  // Shadow registers and fade level update only at frame start; busy flag trails level by a cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_sh   <= VDAC_SCALE;
      tgt_sh    <= FULL;
      level     <= FULL;
      fade_busy <= 1'b0;
    end else begin
      if (frame_start) begin
        mode_sh <= vdac_mode_e'(mode);
        tgt_sh  <= tgt_new;
        level   <= lvl_next;
      end
      fade_busy <= (level != tgt_sh);
    end
  end

endmodule

// File: tb/tb_vdac_pipe.sv
// Self-checking bench for vdac_pipe: directed scenarios plus randomized traffic vs a history model.
module tb_vdac_pipe;

  localparam int IN_W   = 5;
  localparam int OUT_W  = 8;
  localparam int MAXV   = 24;
  localparam int FADE_W = 4;
  localparam int FULL   = 1 << FADE_W;
  localparam int DEPTH  = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] r_in, g_in, b_in;
  logic       blank, hsync, vsync;
  logic [1:0] mode;
  logic [4:0] fade_target;
  logic [3:0] fade_rate;
  logic [7:0] r_o, g_o, b_o;
  logic       hsync_o, vsync_o, fade_busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  vdac_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .MAXV(MAXV), .FADE_W(FADE_W), .SYNC_NEG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .blank(blank), .hsync(hsync), .vsync(vsync), .mode(mode),
    .fade_target(fade_target), .fade_rate(fade_rate),
    .r_o(r_o), .g_o(g_o), .b_o(b_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .fade_busy(fade_busy)
  );

  // Reference model: per-clock history of what was sampled, plus frame-level state.
  int  h_r [DEPTH], h_g [DEPTH], h_b [DEPTH];
  bit  h_bl [DEPTH], h_hs [DEPTH], h_vs [DEPTH], h_ok [DEPTH];
  int  h_mode [DEPTH], h_lvl [DEPTH], h_tgt [DEPTH];
  int  m_mode = 0, m_lvl = FULL, m_tgt = FULL, cyc = 0;
  logic [7:0] e_r, e_g, e_b;
  logic       e_hs, e_vs, e_busy;

  function automatic int f_scale(input int c);
    int cc;
    cc = (c > MAXV) ? MAXV : c;
    return cc * ((1 << OUT_W) - 1) / MAXV;
  endfunction

  function automatic int f_repl(input int c);
    longint acc = 0;
    int bits = 0;
    while (bits < OUT_W) begin
      acc  = (acc << IN_W) | longint'(c);
      bits += IN_W;
    end
    return int'(acc >> (bits - OUT_W));
  endfunction

  function automatic logic [23:0] f_pixel(input int r, input int g, input int b, input int md, input int lvl);
    int v0, v1, v2, y;
    if (md == 1) begin
      v0 = f_repl(r); v1 = f_repl(g); v2 = f_repl(b);
    end else begin
      v0 = f_scale(r); v1 = f_scale(g); v2 = f_scale(b);
      if (md == 2) begin
        y = (5 * v0 + 9 * v1 + 2 * v2) / 16;
        v0 = y; v1 = y; v2 = y;
      end
    end
    return {8'((v0 * lvl) / FULL), 8'((v1 * lvl) / FULL), 8'((v2 * lvl) / FULL)};
  endfunction

  task automatic model_edge();
    int n, m, t;
    logic [23:0] px;
    n = cyc;
    if (!rst_n) begin
      h_r[n] = 0; h_g[n] = 0; h_b[n] = 0;
      h_bl[n] = 1'b1; h_hs[n] = 1'b1; h_vs[n] = 1'b1; h_ok[n] = 1'b0;
      m_mode = 0; m_lvl = FULL; m_tgt = FULL;
    end else begin
      h_r[n] = int'(r_in); h_g[n] = int'(g_in); h_b[n] = int'(b_in);
      h_bl[n] = blank; h_hs[n] = hsync; h_vs[n] = vsync; h_ok[n] = 1'b1;
      if (n >= 2 && h_ok[n-2] && h_ok[n-1] && !h_vs[n-1] && h_vs[n-2]) begin
        m_mode = (mode == 2'd3) ? 0 : int'(mode);
        t = int'(fade_target);
        m_tgt = (t > FULL) ? FULL : t;
        if (fade_rate == 4'd0)            m_lvl = m_tgt;
        else if (m_lvl < m_tgt)           m_lvl = (m_lvl + int'(fade_rate) > m_tgt) ? m_tgt : m_lvl + int'(fade_rate);
        else if (m_lvl > m_tgt)           m_lvl = (m_lvl - int'(fade_rate) < m_tgt) ? m_tgt : m_lvl - int'(fade_rate);
      end
    end
    h_mode[n] = m_mode; h_lvl[n] = m_lvl; h_tgt[n] = m_tgt;
    if (!rst_n || n < 2) begin
      e_r = 8'd0; e_g = 8'd0; e_b = 8'd0; e_hs = 1'b1; e_vs = 1'b1; e_busy = 1'b0;
    end else begin
      m = n - 2;
      e_busy = (h_lvl[n-1] != h_tgt[n-1]);
      if (!h_ok[m] || !h_ok[m+1]) begin
        e_r = 8'd0; e_g = 8'd0; e_b = 8'd0; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        px = f_pixel(h_r[m], h_g[m], h_b[m], h_mode[m], h_lvl[m+1]);
        if (h_bl[m]) px = 24'd0;
        {e_r, e_g, e_b} = px;
        e_hs = h_hs[m]; e_vs = h_vs[m];
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_pix(input int r, input int g, input int b);
    r_in = 5'(r); g_in = 5'(g); b_in = 5'(b);
  endtask

  task automatic frame_pulse(input int md, input int tgt, input int rate);
    mode = 2'(md); fade_target = 5'(tgt); fade_rate = 4'(rate);
    vsync = 1'b0; tick(); tick();
    vsync = 1'b1; tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_pix(0, 0, 0);
    blank = 1'b0; hsync = 1'b1; vsync = 1'b1;
    mode = 2'd0; fade_target = 5'd16; fade_rate = 4'd0;
    repeat (3) tick();
    vectors++;
    if ({r_o, g_o, b_o} !== 24'd0) begin errors++; $display("FAIL reset_rgb: got %06h want 000000", {r_o, g_o, b_o}); end
    vectors++;
    if ({hsync_o, vsync_o} !== 2'b11) begin errors++; $display("FAIL reset_sync: got %b want 11", {hsync_o, vsync_o}); end
    vectors++;
    if (fade_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", fade_busy); end
  endtask

  task automatic test_scale();
    rst_n = 1'b1;
    set_pix(1, 12, 24); hsync = 1'b0; tick();
    set_pix(0, 0, 0);   hsync = 1'b1; tick();
    vectors++;
    if ({r_o, g_o, b_o, hsync_o} !== {24'd0, 1'b1}) begin errors++; $display("FAIL scale_early: got %07h want 0000001", {r_o, g_o, b_o, hsync_o}); end
    tick();
    vectors++;
    if ({r_o, g_o, b_o} !== {8'd10, 8'd127, 8'd255}) begin errors++; $display("FAIL scale_rgb: got %06h want 0a7fff", {r_o, g_o, b_o}); end
    vectors++;
    if (hsync_o !== 1'b0) begin errors++; $display("FAIL scale_hsync: got %b want 0", hsync_o); end
    tick();
    vectors++;
    if (hsync_o !== 1'b1) begin errors++; $display("FAIL scale_hsync_end: got %b want 1", hsync_o); end
  endtask

  task automatic test_replicate();
    frame_pulse(1, 16, 0);
    mode = 2'd0;
    set_pix(22, 0, 31); tick(); set_pix(0, 0, 0); tick(); tick();
    vectors++;
    if ({r_o, b_o} !== {8'hB5, 8'hFF}) begin errors++; $display("FAIL repl_rgb: got %04h want b5ff", {r_o, b_o}); end
    frame_pulse(0, 16, 0);
    set_pix(22, 0, 0); tick(); set_pix(0, 0, 0); tick(); tick();
    vectors++;
    if (r_o !== 8'd233) begin errors++; $display("FAIL repl_back_to_scale: got %0d want 233", r_o); end
  endtask

  task automatic test_grey();
    frame_pulse(2, 16, 0);
    mode = 2'd1;
    set_pix(24, 24, 24); tick();
    set_pix(24, 0, 0);   tick();
    set_pix(0, 0, 0);    tick();
    vectors++;
    if ({r_o, g_o, b_o} !== {3{8'd255}}) begin errors++; $display("FAIL grey_white: got %06h want ffffff", {r_o, g_o, b_o}); end
    tick();
    vectors++;
    if ({r_o, g_o, b_o} !== {3{8'd79}}) begin errors++; $display("FAIL grey_red: got %06h want 4f4f4f", {r_o, g_o, b_o}); end
  endtask

  task automatic test_fade();
    int fade_exp [4] = '{191, 127, 63, 0};
    frame_pulse(0, 16, 0);
    for (int k = 0; k < 4; k++) begin
      frame_pulse(0, 0, 4);
      set_pix(24, 24, 24); tick(); set_pix(0, 0, 0); tick(); tick();
      vectors++;
      if (int'(r_o) != fade_exp[k] || g_o !== r_o || b_o !== r_o) begin
        errors++; $display("FAIL fade_step%0d: got %0d/%0d/%0d want %0d", k, r_o, g_o, b_o, fade_exp[k]);
      end
      vectors++;
      if (fade_busy !== (k < 3)) begin errors++; $display("FAIL fade_busy%0d: got %b want %b", k, fade_busy, k < 3); end
    end
    frame_pulse(0, 16, 0);
    set_pix(24, 24, 24); tick(); set_pix(0, 0, 0); tick(); tick();
    vectors++;
    if ({r_o, fade_busy} !== {8'd255, 1'b0}) begin errors++; $display("FAIL fade_jump: got %03h want 1fe", {r_o, fade_busy}); end
  endtask

  task automatic test_blank();
    for (int i = 0; i < 8; i++) begin
      set_pix(24, 24, 24);
      blank = (i == 2 || i == 3);
      hsync = (i != 3);
      tick();
      if (i >= 2) begin
        vectors++;
        if (int'(r_o) != ((i - 2 == 2 || i - 2 == 3) ? 0 : 255) || hsync_o !== (i - 2 != 3) || vsync_o !== 1'b1) begin
          errors++; $display("FAIL blank_slot%0d: got r=%0d hs=%b vs=%b", i - 2, r_o, hsync_o, vsync_o);
        end
      end
    end
    blank = 1'b0; hsync = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 7) set_pix(25 + i, 25 + i, 25 + i); else set_pix(0, 0, 0);
      tick();
      if (i >= 2) begin
        vectors++;
        if ({r_o, g_o, b_o} !== {3{8'd255}}) begin errors++; $display("FAIL clamp_code%0d: got %06h want ffffff", 23 + i, {r_o, g_o, b_o}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    frame_pulse(0, 0, 4);
    set_pix(24, 24, 24);
    vsync = 1'b0; tick(); tick(); tick();
    vectors++;
    if ({r_o, fade_busy} !== {8'd127, 1'b1}) begin errors++; $display("FAIL rmid_pre: got %03h want 0ff", {r_o, fade_busy}); end
    mode = 2'd1; fade_target = 5'd16; fade_rate = 4'd0;
    rst_n = 1'b0; tick();
    vectors++;
    if ({r_o, g_o, b_o, hsync_o, vsync_o, fade_busy} !== {24'd0, 3'b110}) begin
      errors++; $display("FAIL rmid_reset: got %07h want 0000006", {r_o, g_o, b_o, hsync_o, vsync_o, fade_busy});
    end
    rst_n = 1'b1; tick(); tick(); tick();
    vectors++;
    if ({r_o, vsync_o} !== {8'd255, 1'b0}) begin errors++; $display("FAIL rmid_after: got %03h want 1fe", {r_o, vsync_o}); end
    vsync = 1'b1; mode = 2'd0; tick(); tick();
  endtask

  task automatic test_random();
    int fcnt = 30;
    for (int it = 0; it < 1500; it++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      set_pix($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      blank = ($urandom_range(0, 7) == 0);
      hsync = ($urandom_range(0, 5) != 0);
      mode = 2'($urandom_range(0, 3));
      fade_target = 5'($urandom_range(0, 31));
      fade_rate = 4'($urandom_range(0, 15));
      if (fcnt == 0) fcnt = $urandom_range(20, 60);
      vsync = (fcnt > 3);
      fcnt--;
      tick();
      vectors++;
      if ({r_o, g_o, b_o} !== {e_r, e_g, e_b}) begin
        errors++; $display("FAIL rand_rgb@%0d: got %06h want %06h", it, {r_o, g_o, b_o}, {e_r, e_g, e_b});
      end
      vectors++;
      if ({hsync_o, vsync_o} !== {e_hs, e_vs}) begin
        errors++; $display("FAIL rand_sync@%0d: got %b want %b", it, {hsync_o, vsync_o}, {e_hs, e_vs});
      end
      vectors++;
      if (fade_busy !== e_busy) begin errors++; $display("FAIL rand_busy@%0d: got %b want %b", it, fade_busy, e_busy); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; set_pix(0, 0, 0);
    blank = 1'b0; hsync = 1'b1; vsync = 1'b1;
    mode = 2'd0; fade_target = 5'd16; fade_rate = 4'd0;
    test_reset();
    test_scale();
    test_replicate();
    test_grey();
    test_fade();
    test_blank();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
